accel_spi_responder: RTL and testbench

ACCEL_SPI_RESPONDER -- requirements
Module: accel_spi_responder

---
 rtl/accel_spi_responder_pkg.sv | 46 ++++
 rtl/spi_edge_sync.sv | 59 +++++
 rtl/accel_spi_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_accel_spi_responder.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_spi_responder_pkg.sv
// accel_spi_responder_pkg
//   Shared definitions for the accelerometer SPI responder:
//   - FSM state encoding
//   - SPI command codes
//   - register map addresses and fixed ID bytes
//   - control register reset values
//   - address increment helper (6-bit, wraps 0x3F -> 0x00)
package accel_spi_responder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_IGNORE  = 3'd4,
    ST_WAIT_HI = 3'd5
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ID_DEVID_DEFAULT = 8'hAD;
  localparam logic [7:0] ID_MEMS          = 8'h1D;
  localparam logic [7:0] ID_PART          = 8'hF2;

  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  localparam logic [5:0] ADDR_DEVID  = 6'h00;
  localparam logic [5:0] ADDR_MEMS   = 6'h01;
  localparam logic [5:0] ADDR_PART   = 6'h02;
  localparam logic [5:0] ADDR_XL     = 6'h0E;
  localparam logic [5:0] ADDR_XH     = 6'h0F;
  localparam logic [5:0] ADDR_YL     = 6'h10;
  localparam logic [5:0] ADDR_YH     = 6'h11;
  localparam logic [5:0] ADDR_ZL     = 6'h12;
  localparam logic [5:0] ADDR_ZH     = 6'h13;
  localparam logic [5:0] ADDR_FILTER = 6'h2C;
  localparam logic [5:0] ADDR_POWER  = 6'h2D;

  // Auto-increment across the 64-entry register space; natural 6-bit wrap.
  function automatic logic [5:0] addr_inc(input logic [5:0] addr);
    return addr + 6'd1;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
//   Brings the asynchronous SPI pins into the clock domain and produces
//   single-clock edge pulses from the synchronized values.
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   sclk, mosi, ss         raw SPI pins
//   sclk_rise, sclk_fall   one-clock pulses on synchronized sclk edges
//   ss_rise, ss_fall       one-clock pulses on synchronized ss edges
//   mosi_sync, ss_sync     synchronized mosi / ss levels
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic mosi,
  input  logic ss,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_rise,
  output logic ss_fall,
  output logic mosi_sync,
  output logic ss_sync
);

  logic [SYNC_STAGES-1:0] sclk_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic [SYNC_STAGES-1:0] ss_pipe_r;
  logic                   sclk_prev_r;
  logic                   ss_prev_r;

  // Synchronizer chains plus one delayed copy for edge detection. The ss
  // chain clears to 0 so a deselected bus is only recognised once a high
  // level has actually propagated after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sclk_pipe_r <= {SYNC_STAGES{1'b0}};
      mosi_pipe_r <= {SYNC_STAGES{1'b0}};
      ss_pipe_r   <= {SYNC_STAGES{1'b0}};
      sclk_prev_r <= 1'b0;
      ss_prev_r   <= 1'b0;
    end else begin
      sclk_pipe_r <= {sclk_pipe_r[SYNC_STAGES-2:0], sclk};
      mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], mosi};
      ss_pipe_r   <= {ss_pipe_r[SYNC_STAGES-2:0], ss};
      sclk_prev_r <= sclk_pipe_r[SYNC_STAGES-1];
      ss_prev_r   <= ss_pipe_r[SYNC_STAGES-1];
    end
  end

  // mosi has the same depth as sclk, so mosi_sync is aligned with sclk_rise.
  assign mosi_sync = mosi_pipe_r[SYNC_STAGES-1];
  assign ss_sync   = ss_pipe_r[SYNC_STAGES-1];
  assign sclk_rise = sclk_pipe_r[SYNC_STAGES-1] & ~sclk_prev_r;
  assign sclk_fall = ~sclk_pipe_r[SYNC_STAGES-1] & sclk_prev_r;
  assign ss_rise   = ss_pipe_r[SYNC_STAGES-1] & ~ss_prev_r;
  assign ss_fall   = ~ss_pipe_r[SYNC_STAGES-1] & ss_prev_r;

endmodule

// File: rtl/accel_spi_responder.sv
// accel_spi_responder
//   SPI mode-0 register-file responder for an accelerometer. Command byte
//   (0x0B read / 0x0A write), address byte, then auto-incrementing data bytes.
//   Optional macro ACCEL_RESP_SNAPSHOT_EN: accel samples are captured once per
//   transaction (snap pulses) so multi-byte sample reads are coherent; without
//   it, reads return the live sample taken when each byte is loaded.
// Ports:
//   clock, reset               system clock (>= 8x sclk), sync active-high reset
//   sclk, mosi, ss             SPI from master (ss active low)
//   miso, miso_oe              read data and its output enable
//   accel_x, accel_y, accel_z  unsigned samples (9, 9, 12 bits)
//   power_ctl, filter_ctl      writable control registers (0x2D, 0x2C)
//   snap                       one-clock pulse on sample capture
//   busy                       high from ss-low detection to ss-high detection
module accel_spi_responder
  import accel_spi_responder_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID       = 8'hAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  output logic        miso_oe,
  input  logic [8:0]  accel_x,
  input  logic [8:0]  accel_y,
  input  logic [11:0] accel_z,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        snap,
  output logic        busy
);

  logic        sclk_rise_s;
  logic        sclk_fall_s;
  logic        ss_rise_s;
  logic        ss_fall_s;
  logic        mosi_sync_s;
  logic        ss_sync_s;

  state_t      state_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        is_read_r;
  logic [5:0]  addr_r;
  logic [7:0]  tx_r;

  logic [7:0]  shift_next_s;
  logic        byte_done_s;
  logic        start_s;
  logic [5:0]  addr_next_s;
  logic [7:0]  rd_data_s;
  logic [8:0]  x_src_s;
  logic [8:0]  y_src_s;
  logic [11:0] z_src_s;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss        (ss),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .ss_rise   (ss_rise_s),
    .ss_fall   (ss_fall_s),
    .mosi_sync (mosi_sync_s),
    .ss_sync   (ss_sync_s)
  );

  assign shift_next_s = {shift_r[6:0], mosi_sync_s};
  assign byte_done_s  = sclk_rise_s & (bit_cnt_r == 3'd7);
  assign start_s      = (state_r == ST_IDLE) & ss_fall_s;

`ifdef ACCEL_RESP_SNAPSHOT_EN
  logic [8:0]  snap_x_r;
  logic [8:0]  snap_y_r;
  logic [11:0] snap_z_r;

  // Capture all three samples at transaction start for coherent multi-byte reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_x_r <= 9'd0;
      snap_y_r <= 9'd0;
      snap_z_r <= 12'd0;
    end else if (start_s) begin
      snap_x_r <= accel_x;
      snap_y_r <= accel_y;
      snap_z_r <= accel_z;
    end else begin
      snap_x_r <= snap_x_r;
      snap_y_r <= snap_y_r;
      snap_z_r <= snap_z_r;
    end
  end

  assign x_src_s = snap_x_r;
  assign y_src_s = snap_y_r;
  assign z_src_s = snap_z_r;
`else
  assign x_src_s = accel_x;
  assign y_src_s = accel_y;
  assign z_src_s = accel_z;
`endif

  // Address the byte about to be loaded refers to: the freshly received
  // address after the ADDR byte, or the incremented address after a data byte.
  always_comb begin
    addr_next_s = addr_r;
    if (state_r == ST_ADDR) begin
      addr_next_s = shift_next_s[5:0];
    end else if (state_r == ST_DATA) begin
      addr_next_s = addr_inc(addr_r);
    end else begin
      addr_next_s = addr_r;
    end
  end

  // Register map read mux; samples are zero-extended to 16 bits.
  always_comb begin
    rd_data_s = 8'h00;
    case (addr_next_s)
      ADDR_DEVID:  rd_data_s = DEVID;
      ADDR_MEMS:   rd_data_s = ID_MEMS;
      ADDR_PART:   rd_data_s = ID_PART;
      ADDR_XL:     rd_data_s = x_src_s[7:0];
      ADDR_XH:     rd_data_s = {7'd0, x_src_s[8]};
      ADDR_YL:     rd_data_s = y_src_s[7:0];
      ADDR_YH:     rd_data_s = {7'd0, y_src_s[8]};
      ADDR_ZL:     rd_data_s = z_src_s[7:0];
      ADDR_ZH:     rd_data_s = {4'd0, z_src_s[11:8]};
      ADDR_FILTER: rd_data_s = filter_ctl;
      ADDR_POWER:  rd_data_s = power_ctl;
      default:     rd_data_s = 8'h00;
    endcase
  end

  // Transaction FSM with registered miso/miso_oe/busy/snap and control regs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_WAIT_HI;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      is_read_r  <= 1'b0;
      addr_r     <= 6'h00;
      tx_r       <= 8'h00;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      snap       <= 1'b0;
      busy       <= 1'b0;
      power_ctl  <= POWER_CTL_RST;
      filter_ctl <= FILTER_CTL_RST;
    end else begin
      snap <= 1'b0;
      if (ss_rise_s) begin
        // Deselect aborts everything; a partial byte is simply dropped.
        state_r   <= ST_IDLE;
        bit_cnt_r <= 3'd0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          ST_WAIT_HI: begin
            if (ss_sync_s) begin
              state_r <= ST_IDLE;
            end
          end
          ST_IDLE: begin
            if (start_s) begin
              state_r   <= ST_CMD;
              bit_cnt_r <= 3'd0;
              busy      <= 1'b1;
`ifdef ACCEL_RESP_SNAPSHOT_EN
              snap      <= 1'b1;
`endif
            end
          end
          ST_CMD: begin
            if (sclk_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (byte_done_s) begin
                if (shift_next_s == CMD_READ) begin
                  is_read_r <= 1'b1;
                  state_r   <= ST_ADDR;
                end else if (shift_next_s == CMD_WRITE) begin
                  is_read_r <= 1'b0;
                  state_r   <= ST_ADDR;
                end else begin
                  state_r   <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR: begin
            if (sclk_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (byte_done_s) begin
                addr_r  <= addr_next_s;
                tx_r    <= rd_data_s;
                state_r <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (sclk_rise_s) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (byte_done_s) begin
                if (!is_read_r) begin
                  case (addr_r)
                    ADDR_FILTER: filter_ctl <= shift_next_s;
                    ADDR_POWER:  power_ctl  <= shift_next_s;
                    default:     begin end
                  endcase
                end
                addr_r <= addr_next_s;
                tx_r   <= rd_data_s;
              end
            end else if (sclk_fall_s && is_read_r) begin
              // Mode 0: present the next bit right after each falling edge.
              miso    <= tx_r[7];
              miso_oe <= 1'b1;
              tx_r    <= {tx_r[6:0], 1'b0};
            end
          end
          ST_IGNORE: begin
            miso    <= 1'b0;
            miso_oe <= 1'b0;
          end
          default: begin
            state_r <= ST_WAIT_HI;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_accel_spi_responder.sv
module tb_accel_spi_responder;

  localparam int HALF = 8;  // clocks per sclk half period
`ifdef ACCEL_RESP_SNAPSHOT_EN
  localparam int SNAP_EXP = 1;
`else
  localparam int SNAP_EXP = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic [8:0]  accel_x;
  logic [8:0]  accel_y;
  logic [11:0] accel_z;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  power_ctl;
  logic [7:0]  filter_ctl;
  logic        snap;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_pwr  = 8'h00;
  logic [7:0]  m_filt = 8'h13;
  logic [8:0]  sx = 9'd0;
  logic [8:0]  sy = 9'd0;
  logic [11:0] sz = 12'd0;
  logic [8:0]  chg_x = 9'd0;
  bit          idle_chk   = 1'b0;
  bit          mid_chk    = 1'b0;
  bit          oe_off_chk = 1'b0;
  int          snap_cnt   = 0;
  logic [7:0]  tx_bytes [0:7];
  logic [7:0]  rx_bytes [0:7];
  logic [5:0]  addr_pool [0:13] = '{6'h00, 6'h01, 6'h02, 6'h0E, 6'h0F, 6'h10, 6'h11,
                                   6'h12, 6'h13, 6'h2C, 6'h2D, 6'h3E, 6'h3F, 6'h20};

  always #5 clock = ~clock;

  accel_spi_responder dut (
    .clock      (clock),
    .reset      (reset),
    .sclk       (sclk),
    .mosi       (mosi),
    .ss         (ss),
    .miso       (miso),
    .miso_oe    (miso_oe),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_z    (accel_z),
    .power_ctl  (power_ctl),
    .filter_ctl (filter_ctl),
    .snap       (snap),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Register map as seen by the master; samples viewed as 16-bit zero-extended values.
  function automatic logic [7:0] m_read(input logic [5:0] a);
    logic [15:0] xv, yv, zv;
    logic [7:0]  r;
`ifdef ACCEL_RESP_SNAPSHOT_EN
    xv = 16'(sx); yv = 16'(sy); zv = 16'(sz);
`else
    xv = 16'(accel_x); yv = 16'(accel_y); zv = 16'(accel_z);
`endif
    case (a)
      6'h00: r = 8'hAD;
      6'h01: r = 8'h1D;
      6'h02: r = 8'hF2;
      6'h0E: r = xv[7:0];
      6'h0F: r = xv[15:8];
      6'h10: r = yv[7:0];
      6'h11: r = yv[15:8];
      6'h12: r = zv[7:0];
      6'h13: r = zv[15:8];
      6'h2C: r = m_filt;
      6'h2D: r = m_pwr;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Per-cycle comparison of the DUT against the model's expected bus state.
  always @(negedge clock) begin
    if (idle_chk) begin
      check("idle_busy", 16'(busy), 16'd0);
      check("idle_oe", 16'(miso_oe), 16'd0);
      check("idle_miso", 16'(miso), 16'd0);
      check("idle_snap", 16'(snap), 16'd0);
      check("power_ctl", 16'(power_ctl), 16'(m_pwr));
      check("filter_ctl", 16'(filter_ctl), 16'(m_filt));
    end
    if (mid_chk) check("busy", 16'(busy), 16'd1);
    if (oe_off_chk) begin
      check("oe_off", 16'(miso_oe), 16'd0);
      check("miso_off", 16'(miso), 16'd0);
    end
    if (snap) snap_cnt++;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One mode-0 bit: master sets mosi, raises sclk (sampling miso/oe), lowers sclk.
  task automatic bit_xfer(input logic b, output logic r, output logic o);
    mosi = b;
    clks(HALF);
    sclk = 1'b1;
    r = miso;
    o = miso_oe;
    clks(HALF);
    sclk = 1'b0;
  endtask

  task automatic rand_accel();
    accel_x = 9'($urandom);
    accel_y = 9'($urandom);
    accel_z = 12'($urandom);
  endtask

  // Full transaction of nbits from tx_bytes, checked against the model.
  task automatic spi_xfer(input int nbits, input int chg_at);
    logic [7:0] rx, exp_b;
    logic       r, o;
    logic [5:0] a;
    int         mode;
    rx = 8'h00; exp_b = 8'h00; a = 6'h00; mode = 0;
    idle_chk = 1'b0;
    snap_cnt = 0;
    sx = accel_x; sy = accel_y; sz = accel_z;
    ss = 1'b0;
    clks(HALF);
    mid_chk = 1'b1;
    oe_off_chk = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      bit_xfer(tx_bytes[i/8][7 - (i % 8)], r, o);
      rx = {rx[6:0], r};
      if (mode == 1 && i >= 16) check("read_oe", 16'(o), 16'd1);
      if (i % 8 == 7) begin
        if (i == 7) begin
          if (tx_bytes[0] == 8'h0B) mode = 1;
          else if (tx_bytes[0] == 8'h0A) mode = 2;
          else mode = 0;
        end else if (i == 15) begin
          a = tx_bytes[1][5:0];
          exp_b = m_read(a);
          if (mode == 1) oe_off_chk = 1'b0;
        end else if (mode == 1) begin
          check("read_byte", 16'(rx), 16'(exp_b));
          rx_bytes[i/8 - 2] = rx;
          a = a + 6'd1;
          exp_b = m_read(a);
        end else if (mode == 2) begin
          if (a == 6'h2C) m_filt = tx_bytes[i/8];
          else if (a == 6'h2D) m_pwr = tx_bytes[i/8];
          check("wr_power", 16'(power_ctl), 16'(m_pwr));
          check("wr_filter", 16'(filter_ctl), 16'(m_filt));
          a = a + 6'd1;
        end
      end
      if (i == chg_at) begin
        rand_accel();
        accel_x = chg_x;
      end
    end
    mid_chk = 1'b0;
    ss = 1'b1;
    clks(2 * HALF);
    oe_off_chk = 1'b0;
    check("snap_count", 16'(snap_cnt), 16'(SNAP_EXP));
    idle_chk = 1'b1;
    clks(HALF);
  endtask

  initial begin
    logic r, o;
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    rand_accel();
    for (int k = 0; k < 8; k++) begin tx_bytes[k] = 8'h00; rx_bytes[k] = 8'h00; end
    clks(4);
    reset = 1'b0;
    clks(2 * HALF);
    check("rst_power", 16'(power_ctl), 16'h00);
    check("rst_filter", 16'(filter_ctl), 16'h13);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_oe", 16'(miso_oe), 16'd0);
    check("rst_snap", 16'(snap), 16'd0);
    idle_chk = 1'b1;

    // ID bytes in sequence
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h00;
    spi_xfer(40, -1);
    check("devid_lit", 16'(rx_bytes[0]), 16'hAD);
    check("mems_lit", 16'(rx_bytes[1]), 16'h1D);
    check("part_lit", 16'(rx_bytes[2]), 16'hF2);

    // write power_ctl then read it back
    tx_bytes[0] = 8'h0A; tx_bytes[1] = 8'h2D; tx_bytes[2] = 8'h02;
    spi_xfer(24, -1);
    check("power_lit", 16'(power_ctl), 16'h02);
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h2D; tx_bytes[2] = 8'h00;
    spi_xfer(24, -1);
    check("power_rb_lit", 16'(rx_bytes[0]), 16'h02);

    // accel_x changes mid-transfer
    accel_x = 9'd385; chg_x = 9'd80;
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h0E;
    spi_xfer(32, 19);
    check("xl_lit", 16'(rx_bytes[0]), 16'h81);
`ifdef ACCEL_RESP_SNAPSHOT_EN
    check("xh_lit", 16'(rx_bytes[1]), 16'h01);
`else
    check("xh_lit", 16'(rx_bytes[1]), 16'h00);
`endif

    // address wrap
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h3F;
    spi_xfer(32, -1);
    check("wrap0_lit", 16'(rx_bytes[0]), 16'h00);
    check("wrap1_lit", 16'(rx_bytes[1]), 16'hAD);

    // partial data byte must not write
    tx_bytes[0] = 8'h0A; tx_bytes[1] = 8'h2C; tx_bytes[2] = 8'hFF;
    spi_xfer(21, -1);
    check("partial_lit", 16'(filter_ctl), 16'h13);
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h2C;
    spi_xfer(24, -1);
    check("filter_rb_lit", 16'(rx_bytes[0]), 16'h13);

    // reset during a read with ss held low
    idle_chk = 1'b0;
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h00;
    ss = 1'b0;
    clks(HALF);
    for (int i = 0; i < 20; i++) begin
      bit_xfer((i < 16) ? tx_bytes[i/8][7 - (i % 8)] : 1'b0, r, o);
      if (i >= 16) check("pre_rst_oe", 16'(o), 16'd1);
    end
    reset = 1'b1;
    clks(3);
    reset = 1'b0;
    m_pwr = 8'h00; m_filt = 8'h13;
    oe_off_chk = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bit_xfer(1'($urandom), r, o);
      check("post_rst_oe", 16'(o), 16'd0);
    end
    check("post_rst_busy", 16'(busy), 16'd0);
    check("post_rst_power", 16'(power_ctl), 16'h00);
    ss = 1'b1;
    clks(2 * HALF);
    oe_off_chk = 1'b0;
    idle_chk = 1'b1;
    clks(HALF);

    // unknown command never drives
    tx_bytes[0] = 8'h55; tx_bytes[1] = 8'h0B; tx_bytes[2] = 8'h00; tx_bytes[3] = 8'h0B;
    spi_xfer(32, -1);

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      int kind, nd, part, chg;
      kind = $urandom_range(0, 9);
      if (kind < 6) tx_bytes[0] = 8'h0B;
      else if (kind < 9) tx_bytes[0] = 8'h0A;
      else tx_bytes[0] = 8'($urandom);
      tx_bytes[1] = {2'($urandom), addr_pool[$urandom_range(0, 13)]};
      for (int k = 2; k < 8; k++) tx_bytes[k] = 8'($urandom);
      nd = $urandom_range(1, 5);
      part = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
      chg = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(16, 16 + 8 * nd - 1));
      chg_x = 9'($urandom);
      rand_accel();
      spi_xfer(16 + 8 * nd + part, chg);
    end

    // recovery read after everything
    tx_bytes[0] = 8'h0B; tx_bytes[1] = 8'h00;
    spi_xfer(24, -1);
    check("final_devid_lit", 16'(rx_bytes[0]), 16'hAD);

    idle_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
